emu_scan_ctrl: RTL and testbench

- Checkpoint sequencer sitting directly upstream of the emulated DUT's scan ports.
- Drives the DUT pause, FF scan and RAM scan controls. Gates the DUT clock by holding pause.
- Save: streams both chains out to the host. Restore: streams host data into both chains.
- Feeds the FF$SE/DI and RAM$SE/SD/DI pins of the transformed DUT, and the pause term of its ClockGate.

---
 rtl/emu_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_emu_scan_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_scan_ctrl.sv
// Checkpoint sequencer for the emulated DUT's FF and RAM scan chains (save/restore).
// Optional CRC-32 over the transferred words is compiled in with EMU_SCAN_CRC_EN.
module emu_scan_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FF_WORDS   = 16,
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_pause,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  output logic                  busy,
  output logic                  done,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din_data,
  output logic                  pause,
  output logic                  ff_scan,
  output logic                  ff_dir,
  output logic [DATA_WIDTH-1:0] ff_sdi,
  input  logic [DATA_WIDTH-1:0] ff_sdo,
  output logic                  ram_scan,
  output logic                  ram_dir,
  output logic [DATA_WIDTH-1:0] ram_sdi,
  input  logic [DATA_WIDTH-1:0] ram_sdo
`ifdef EMU_SCAN_CRC_EN
  ,
  output logic [31:0]           crc
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_FF,
    S_RAM,
    S_FIN
  } state_t;

  localparam logic [CNT_W-1:0] FF_LAST  = CNT_W'(FF_WORDS - 32'd1);
  localparam logic [CNT_W-1:0] RAM_LAST = CNT_W'((RAM_WORDS == 32'd0) ? 32'd0 : RAM_WORDS - 32'd1);
  localparam bit               HAS_RAM  = (RAM_WORDS != 32'd0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;

  logic w_ff_ph;
  logic w_ram_ph;
  logic w_act;
  logic w_hs;
  logic w_xfer;
  logic w_last;

  // Shift phases are masked by rst so scan enables drop in the reset cycle itself.
  assign w_ff_ph  = (r_state == S_FF)  && !rst;
  assign w_ram_ph = (r_state == S_RAM) && !rst;
  assign w_act    = w_ff_ph || w_ram_ph;
  assign w_hs     = r_dir ? din_valid : dout_ready;
  assign w_xfer   = w_act && w_hs;
  assign w_last   = w_ff_ph ? (r_cnt == FF_LAST) : (r_cnt == RAM_LAST);

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FIN);
  assign pause      = host_pause || busy;

  assign dout_valid = w_act && !r_dir;
  assign din_ready  = w_act && r_dir;
  assign dout_data  = (r_state == S_RAM) ? ram_sdo : ff_sdo;

  // Save recirculates the chains so the checkpointed state survives the scan.
  assign ff_scan  = w_ff_ph && w_hs;
  assign ff_dir   = w_ff_ph && r_dir;
  assign ff_sdi   = din_data;
  assign ram_scan = w_ram_ph && w_hs;
  assign ram_dir  = r_dir;
  assign ram_sdi  = r_dir ? din_data : ram_sdo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_dir   <= cmd_dir;
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: r_state <= S_FF;
        S_FF: begin
          if (w_xfer) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= HAS_RAM ? S_RAM : S_FIN;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_RAM: begin
          if (w_xfer) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_FIN;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef EMU_SCAN_CRC_EN
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam int unsigned NBYTES   = DATA_WIDTH / 8;

  // MSB-first CRC-32 over one word, least significant byte first.
  function automatic logic [31:0] crc_word(input logic [31:0] c_in,
                                           input logic [DATA_WIDTH-1:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < int'(NBYTES); b++) begin
      c = c ^ {d[b*8 +: 8], 24'h000000};
      for (int k = 0; k < 8; k++) begin
        c = c[31] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
    end
    return c;
  endfunction

  logic [31:0]           r_crc;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_word = r_dir ? din_data : dout_data;
  assign crc    = r_crc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc <= CRC_INIT;
    end else if ((r_state == S_IDLE) && cmd_valid) begin
      r_crc <= CRC_INIT;
    end else if (w_xfer) begin
      r_crc <= crc_word(r_crc, w_word);
    end
  end
`endif

endmodule

// File: tb/tb_emu_scan_ctrl.sv
// Directed bench for emu_scan_ctrl: chain models, scoreboarded save streams, protocol checks.
module tb_emu_scan_ctrl;

  localparam int DW = 64;

  logic clk, rst, host_pause, seed;

  logic          a_cmd_valid, a_cmd_ready, a_cmd_dir, a_busy, a_done;
  logic          a_dout_valid, a_dout_ready, a_din_valid, a_din_ready;
  logic [DW-1:0] a_dout_data, a_din_data;
  logic          a_pause, a_ff_scan, a_ff_dir, a_ram_scan, a_ram_dir;
  logic [DW-1:0] a_ff_sdi, a_ff_sdo, a_ram_sdi, a_ram_sdo;

  logic          b_cmd_valid, b_cmd_ready, b_cmd_dir, b_busy, b_done;
  logic          b_dout_valid, b_dout_ready, b_din_valid, b_din_ready;
  logic [DW-1:0] b_dout_data, b_din_data;
  logic          b_pause, b_ff_scan, b_ff_dir, b_ram_scan, b_ram_dir;
  logic [DW-1:0] b_ff_sdi, b_ff_sdo, b_ram_sdi, b_ram_sdo;
`ifdef EMU_SCAN_CRC_EN
  logic [31:0]   a_crc, b_crc;
`endif

  emu_scan_ctrl #(.DATA_WIDTH(DW), .FF_WORDS(4), .RAM_WORDS(8), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .host_pause(host_pause),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_dir(a_cmd_dir),
    .busy(a_busy), .done(a_done),
    .dout_valid(a_dout_valid), .dout_ready(a_dout_ready), .dout_data(a_dout_data),
    .din_valid(a_din_valid), .din_ready(a_din_ready), .din_data(a_din_data),
    .pause(a_pause), .ff_scan(a_ff_scan), .ff_dir(a_ff_dir), .ff_sdi(a_ff_sdi), .ff_sdo(a_ff_sdo),
    .ram_scan(a_ram_scan), .ram_dir(a_ram_dir), .ram_sdi(a_ram_sdi), .ram_sdo(a_ram_sdo)
`ifdef EMU_SCAN_CRC_EN
    , .crc(a_crc)
`endif
  );

  emu_scan_ctrl #(.DATA_WIDTH(DW), .FF_WORDS(4), .RAM_WORDS(0), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .host_pause(host_pause),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_dir(b_cmd_dir),
    .busy(b_busy), .done(b_done),
    .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout_data(b_dout_data),
    .din_valid(b_din_valid), .din_ready(b_din_ready), .din_data(b_din_data),
    .pause(b_pause), .ff_scan(b_ff_scan), .ff_dir(b_ff_dir), .ff_sdi(b_ff_sdi), .ff_sdo(b_ff_sdo),
    .ram_scan(b_ram_scan), .ram_dir(b_ram_dir), .ram_sdi(b_ram_sdi), .ram_sdo(b_ram_sdo)
`ifdef EMU_SCAN_CRC_EN
    , .crc(b_crc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int cnt_ff, cnt_ram, n_acc, n_done, acc_cyc, done_cyc;
  int b_cnt_ram, b_n_done, b_acc_cyc, b_done_cyc;
  logic exp_dir;
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic [DW-1:0] exp_words[12];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat_a(input int i);
    return (i < 4) ? (64'hF0F0_0000_0000_0000 + 64'(i)) : (64'h5A5A_0000_0000_0000 + 64'(i - 4));
  endfunction

  // Bit-serial reference CRC-32 (poly 04C11DB7, no reflection), LSB byte first.
  function automatic logic [31:0] sw_crc(input logic [31:0] c_in, input logic [DW-1:0] w);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int b = 0; b < DW / 8; b++) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[31] ^ w[b*8 + k];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    end
    return c;
  endfunction

  // Behavioural scan chains: word 0 drives sdo, new words enter at the tail.
  logic [DW-1:0] ff_a [4];
  logic [DW-1:0] ram_a[8];
  logic [DW-1:0] ff_b [4];
  assign a_ff_sdo  = ff_a[0];
  assign a_ram_sdo = ram_a[0];
  assign b_ff_sdo  = ff_b[0];
  assign b_ram_sdo = '0;

  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 4; i++) ff_a[i] <= pat_a(i);
      for (int i = 0; i < 8; i++) ram_a[i] <= pat_a(i + 4);
      for (int i = 0; i < 4; i++) ff_b[i] <= 64'hBEEF_0000_0000_0000 + 64'(i);
    end else begin
      if (a_ff_scan) begin
        for (int i = 0; i < 3; i++) ff_a[i] <= ff_a[i+1];
        ff_a[3] <= a_ff_dir ? a_ff_sdi : ff_a[0];
      end
      if (a_ram_scan) begin
        for (int i = 0; i < 7; i++) ram_a[i] <= ram_a[i+1];
        ram_a[7] <= a_ram_sdi;
      end
      if (b_ff_scan) begin
        for (int i = 0; i < 3; i++) ff_b[i] <= ff_b[i+1];
        ff_b[3] <= b_ff_dir ? b_ff_sdi : ff_b[0];
      end
    end
  end

  // Monitor for instance A (FF=4, RAM=8).
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("a_scan_vs_hs", 64'(a_ff_scan | a_ram_scan),
          64'((a_dout_valid & a_dout_ready) | (a_din_valid & a_din_ready)));
      chk("a_scan_excl", 64'(a_ff_scan & a_ram_scan), 64'(0));
      if (a_busy) chk("a_pause_busy", 64'(a_pause), 64'(1));
      if (a_ff_scan) begin cnt_ff++; chk("a_ff_dir", 64'(a_ff_dir), 64'(exp_dir)); end
      if (a_ram_scan) begin cnt_ram++; chk("a_ram_dir", 64'(a_ram_dir), 64'(exp_dir)); end
      if (a_dout_valid && a_dout_ready) begin
        n_chk++;
        assert (q_a.size() != 0) else begin
          n_fail++;
          $error("FAIL a_dout_unexpected observed=%0h expected=none", a_dout_data);
        end
        if (q_a.size() != 0) chk("a_dout_data", a_dout_data, q_a.pop_front());
      end
      if (a_cmd_valid && a_cmd_ready) begin n_acc++; acc_cyc = cyc; end
      if (a_done) begin n_done++; done_cyc = cyc; end
    end
  end

  // Monitor for instance B (FF=4, no RAM chain).
  always @(negedge clk) begin
    if (!rst) begin
      if (b_ram_scan) b_cnt_ram++;
      if (b_dout_valid && b_dout_ready) begin
        n_chk++;
        assert (q_b.size() != 0) else begin
          n_fail++;
          $error("FAIL b_dout_unexpected observed=%0h expected=none", b_dout_data);
        end
        if (q_b.size() != 0) chk("b_dout_data", b_dout_data, q_b.pop_front());
      end
      if (b_cmd_valid && b_cmd_ready) b_acc_cyc = cyc;
      if (b_done) begin b_n_done++; b_done_cyc = cyc; end
    end
  end

  task automatic clr();
    cnt_ff = 0; cnt_ram = 0; n_acc = 0; n_done = 0;
  endtask

  task automatic issue_cmd_a(input logic d);
    a_cmd_valid = 1'b1; a_cmd_dir = d; exp_dir = d;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
  endtask

  task automatic wait_done_a(input int lim);
    for (int t = 0; t < lim; t++) begin
      @(negedge clk);
      if (a_done) return;
    end
    chk("a_done_timeout", 64'(0), 64'(1));
  endtask

  task automatic post_op_a(input int ff_n, input int ram_n);
    @(negedge clk);
    chk("a_done_one_cycle", 64'(a_done), 64'(0));
    chk("a_busy_after", 64'(a_busy), 64'(0));
    chk("a_ready_after", 64'(a_cmd_ready), 64'(1));
    chk("a_ff_enables", 64'(cnt_ff), 64'(ff_n));
    chk("a_ram_enables", 64'(cnt_ram), 64'(ram_n));
    chk("a_done_pulses", 64'(n_done), 64'(1));
    chk("a_accepts", 64'(n_acc), 64'(1));
    chk("a_queue_left", 64'(q_a.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic run_save_a();
    logic [31:0] c;
    clr();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 12; i++) begin q_a.push_back(exp_words[i]); c = sw_crc(c, exp_words[i]); end
    a_dout_ready = 1'b1;
    issue_cmd_a(1'b0);
    wait_done_a(100);
`ifdef EMU_SCAN_CRC_EN
    chk("a_crc", 64'(a_crc), 64'(c));
`endif
    post_op_a(4, 8);
    chk("a_save_latency", 64'(done_cyc - acc_cyc), 64'(14));
  endtask

  int   idx;
  logic hs;

  initial begin
    rst = 1'b1; seed = 1'b1; host_pause = 1'b0; exp_dir = 1'b0;
    a_cmd_valid = 0; a_cmd_dir = 0; a_dout_ready = 0; a_din_valid = 0; a_din_data = '0;
    b_cmd_valid = 0; b_cmd_dir = 0; b_dout_ready = 1; b_din_valid = 0; b_din_data = '0;
    b_cnt_ram = 0; b_n_done = 0; b_acc_cyc = 0; b_done_cyc = 0;
    clr(); acc_cyc = 0; done_cyc = 0;
    for (int i = 0; i < 12; i++) exp_words[i] = pat_a(i);
    repeat (3) @(posedge clk);
    #1 seed = 1'b0;

    // Reset state while rst is held.
    @(negedge clk);
    chk("rst_cmd_ready", 64'(a_cmd_ready), 64'(1));
    chk("rst_busy", 64'(a_busy), 64'(0));
    chk("rst_done", 64'(a_done), 64'(0));
    chk("rst_scan", 64'({a_ff_scan, a_ram_scan, a_dout_valid, a_din_ready}), 64'(0));
    chk("rst_pause_lo", 64'(a_pause), 64'(0));
    host_pause = 1'b1; #1;
    chk("rst_pause_hi", 64'(a_pause), 64'(1));
    host_pause = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // RAM_WORDS=0 instance: FF phase then FIN directly.
    begin
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 4; i++) begin
        q_b.push_back(64'hBEEF_0000_0000_0000 + 64'(i));
        c = sw_crc(c, 64'hBEEF_0000_0000_0000 + 64'(i));
      end
      b_cmd_valid = 1'b1;
      @(posedge clk); #1 b_cmd_valid = 1'b0;
      for (int t = 0; t < 50 && b_n_done == 0; t++) @(posedge clk);
      #1;
      chk("b_done_pulses", 64'(b_n_done), 64'(1));
      chk("b_latency", 64'(b_done_cyc - b_acc_cyc), 64'(6));
      chk("b_ram_enables", 64'(b_cnt_ram), 64'(0));
      chk("b_queue_left", 64'(q_b.size()), 64'(0));
`ifdef EMU_SCAN_CRC_EN
      chk("b_crc", 64'(b_crc), 64'(c));
`endif
      @(posedge clk); #1;
    end

    // Two full-rate saves: identical streams, chain preserved.
    run_save_a();
    run_save_a();

    // Restore 0x1000+i with random valid gaps.
    clr();
    a_dout_ready = 1'b0;
    issue_cmd_a(1'b1);
    idx = 0; a_din_valid = 1'b1; a_din_data = 64'h1000;
    for (int t = 0; t < 300 && n_done == 0; t++) begin
      @(negedge clk);
      hs = a_din_valid & a_din_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      a_din_valid = (idx < 12) && ($urandom_range(0, 3) != 0);
      a_din_data  = 64'h1000 + 64'(idx);
    end
    a_din_valid = 1'b0;
    chk("a_restore_words", 64'(idx), 64'(12));
    chk("a_restore_ff_en", 64'(cnt_ff), 64'(4));
    chk("a_restore_ram_en", 64'(cnt_ram), 64'(8));
    chk("a_restore_done", 64'(n_done), 64'(1));
    for (int i = 0; i < 12; i++) exp_words[i] = 64'h1000 + 64'(i);
    @(posedge clk); #1;

    // Save back what was restored.
    run_save_a();

    // Save with dout_ready pattern 1,0,0,1,0,0,...
    clr();
    for (int i = 0; i < 12; i++) q_a.push_back(exp_words[i]);
    a_dout_ready = 1'b1;
    issue_cmd_a(1'b0);
    for (int k = 1; k < 300 && n_done == 0; k++) begin
      a_dout_ready = (k % 3 == 0);
      @(posedge clk); #1;
    end
    a_dout_ready = 1'b1;
    post_op_a(4, 8);

    // cmd_valid held while busy: ignored, single done.
    clr();
    for (int i = 0; i < 12; i++) q_a.push_back(exp_words[i]);
    a_cmd_valid = 1'b1; a_cmd_dir = 1'b0; exp_dir = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("a_busy_cmd_ready", 64'(a_cmd_ready), 64'(0));
    chk("a_busy_flag", 64'(a_busy), 64'(1));
    repeat (4) @(posedge clk);
    #1 a_cmd_valid = 1'b0;
    wait_done_a(100);
    post_op_a(4, 8);
    repeat (5) @(posedge clk);
    #1;
    chk("a_busy_cmd_done_total", 64'(n_done), 64'(1));
    chk("a_busy_cmd_accepts", 64'(n_acc), 64'(1));

    // Reset during the third FF beat.
    clr();
    for (int i = 0; i < 12; i++) q_a.push_back(exp_words[i]);
    issue_cmd_a(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; host_pause = 1'b1;
    @(negedge clk);
    chk("a_rst_same_cycle_scan", 64'(a_ff_scan | a_ram_scan), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("a_rst_ff_scan", 64'(a_ff_scan), 64'(0));
    chk("a_rst_busy", 64'(a_busy), 64'(0));
    chk("a_rst_cmd_ready", 64'(a_cmd_ready), 64'(1));
    chk("a_rst_pause_hi", 64'(a_pause), 64'(1));
    chk("a_rst_words_seen", 64'(q_a.size()), 64'(10));
    host_pause = 1'b0; #1;
    chk("a_rst_pause_lo", 64'(a_pause), 64'(0));
    q_a.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
